gpio_bank: RTL and testbench
============================

GPIO_BANK -- requirements
Module: gpio_bank

Interface
REQ-001 Parameter WIDTH, default 8: bit count of the GPO and GPI ports and of every register; legal range 1..32.
REQ-002 Parameter DEB_CYCLES, default 16: debounce stability count in clk_fpga cycles; legal range 2..65535.
REQ-003 Parameter EDGE_MODE, default 0: interrupt edge selection; 0 = rising, 1 = falling, 2 = both.
REQ-004 clk_fpga  input  1  single system clock; all logic is on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 gpi  input  WIDTH  asynchronous external inputs (switches).
REQ-007 gpo  output  WIDTH  registered general-purpose outputs (LEDs).
REQ-008 addr  input  2  register select; 0 = GPO (RW), 1 = GPI (RO), 2 = IRQ_MASK (RW), 3 = IRQ_STATUS (RW1C).
REQ-009 we  input  1  write strobe, one cycle per write.
REQ-010 re  input  1  read strobe, one cycle per read.
REQ-011 wdata  input  WIDTH  write data.
REQ-012 rdata  output  WIDTH  read data, registered.
REQ-013 rvalid  output  1  one-cycle pulse that qualifies rdata.
REQ-014 irq  output  1  registered level interrupt.

Function
REQ-015 gpi SHALL pass through a 2-flop synchronizer per bit before any other use.
REQ-016 A write with addr 0 SHALL update gpo on the next clock edge.
REQ-017 A write with addr 2 SHALL update IRQ_MASK. A write with addr 1 SHALL have no effect.
REQ-018 A write with addr 3 SHALL clear every IRQ_STATUS bit where wdata is 1 and leave the other bits unchanged.
REQ-019 A read SHALL drive rdata with the addressed register and assert rvalid for exactly one cycle, both on the edge after re. rdata SHALL hold its value at other times.
REQ-020 When re and we are asserted in the same cycle, rdata SHALL return the value before the write.
REQ-021 Each debounced bit SHALL change only after the synchronized bit has differed from it for DEB_CYCLES consecutive cycles. Any reversion before then SHALL reset that bit's counter to 0.
REQ-022 An edge of a debounced bit that matches EDGE_MODE SHALL set the corresponding IRQ_STATUS bit on the following edge.
REQ-023 IRQ_STATUS bits SHALL be set regardless of IRQ_MASK.
REQ-024 When an edge event and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-025 irq SHALL equal the OR-reduction of (IRQ_STATUS AND IRQ_MASK), registered one cycle.
REQ-026 Counters SHALL saturate and not wrap. Counter width SHALL be clog2(DEB_CYCLES+1).

Reset
REQ-027 While reset_n is low, the following SHALL be 0: gpo, rdata, rvalid, irq, IRQ_MASK, IRQ_STATUS, all debounce counters and all synchronizer flops.
REQ-028 The debounced register SHALL reset to 0. An input that is held high SHALL therefore produce one rising event DEB_CYCLES cycles after release.
REQ-029 A reset asserted mid-debounce or mid-read SHALL abort that operation. No rvalid SHALL be issued for a read that was in flight.

Configuration
REQ-030 Macro GPIO_DEBOUNCE_EN: when defined, the debounce of REQ-021 SHALL be compiled in.
REQ-031 When GPIO_DEBOUNCE_EN is undefined, the debounced value SHALL equal the synchronized value (input-to-GPI latency 2 cycles). No counters SHALL be generated and DEB_CYCLES SHALL be ignored.

Verification
REQ-032 Write addr0 wdata 0xA5 -> gpo = 0xA5 one cycle later; read addr0 -> rdata 0xA5 with rvalid one cycle after re.
REQ-033 DEB_CYCLES = 16, gpi[0] 0->1 held -> GPI[0] reads 1 at 2+16 cycles ±1. A 10-cycle glitch -> GPI unchanged and no status set.
REQ-034 EDGE_MODE = 0, IRQ_MASK = 0x01, gpi[0] rises -> IRQ_STATUS = 0x01 and irq = 1. W1C 0x01 -> irq = 0 two cycles later.
REQ-035 IRQ_MASK = 0x00, gpi[3] rises -> IRQ_STATUS = 0x08 and irq stays 0. Write IRQ_MASK = 0x08 -> irq = 1.
REQ-036 Edge event on bit 2 in the same cycle as W1C 0x04 -> IRQ_STATUS[2] = 1.
REQ-037 reset_n pulled low mid-debounce with gpi = 0xFF -> all outputs 0. After release, GPI = 0xFF after DEB_CYCLES+2 cycles and IRQ_STATUS = 0xFF.

Source files
------------

// File: rtl/gpio_bank_if.sv
// gpio_bank_if -- register bus between a host and gpio_bank.
//   addr   : register select (0 GPO, 1 GPI, 2 IRQ_MASK, 3 IRQ_STATUS)
//   we/re  : single-cycle write / read strobes
//   wdata  : write data
//   rdata  : registered read data, qualified by the one-cycle rvalid pulse
// master drives the request side, slave (the bank) returns rdata/rvalid.
interface gpio_bank_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       addr;
  logic             we;
  logic             re;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             rvalid;

  modport master (output addr, we, re, wdata, input rdata, rvalid);
  modport slave  (input addr, we, re, wdata, output rdata, rvalid);
endinterface

// File: rtl/gpio_bank.sv
// gpio_bank -- WIDTH-bit GPIO bank: registered outputs, synchronized (and
// optionally debounced) inputs, edge-triggered sticky interrupt status.
//
// Ports
//   clk_fpga : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   gpi      : asynchronous external inputs
//   gpo      : registered outputs (register 0)
//   irq      : registered level interrupt, |(IRQ_STATUS & IRQ_MASK)
//   bus      : gpio_bank_if.slave register port
//
// Build option: define GPIO_DEBOUNCE_EN to insert a per-bit debounce filter
// of DEB_CYCLES cycles after the synchronizer. Without it the debounced
// value is the synchronized value and DEB_CYCLES is not used.

`ifdef GPIO_DEBOUNCE_EN
// One debounce lane: deb follows sync_in once sync_in has disagreed with it
// for DEB_CYCLES consecutive cycles; any agreement restarts the count.
module gpio_deb_lane #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk_fpga,
  input  logic reset_n,
  input  logic sync_in,
  output logic deb
);
  localparam int             CW   = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]  CMAX = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // The cycle that completes the run (cnt == DEB_CYCLES-1) flips deb, so
  // the count never climbs past CMAX and cannot wrap.
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (sync_in == deb) begin
      cnt <= '0;
    end else if (cnt >= CMAX) begin
      cnt <= '0;
      deb <= sync_in;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule
`endif

module gpio_bank #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 16,
  parameter int EDGE_MODE  = 0
) (
  input  logic             clk_fpga,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gpi,
  output logic [WIDTH-1:0] gpo,
  output logic             irq,
  gpio_bank_if.slave       bus
);
  logic [WIDTH-1:0] sync1, sync2;
  logic [WIDTH-1:0] deb, deb_prev, edge_ev;
  logic [WIDTH-1:0] irq_mask, irq_stat, w1c, rd_mux;
  logic             wr_gpo, wr_mask, wr_stat;

  // Two-flop synchronizer, nothing else looks at raw gpi.
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpi;
      sync2 <= sync1;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    gpio_deb_lane #(.DEB_CYCLES(DEB_CYCLES)) u_lane (
      .clk_fpga (clk_fpga),
      .reset_n  (reset_n),
      .sync_in  (sync2[i]),
      .deb      (deb[i])
    );
  end
`else
  localparam int deb_cycles_unused = DEB_CYCLES;
  assign deb = sync2;
`endif

  // deb_prev holds last cycle's debounced value; the edge is seen the cycle
  // after deb moves and lands in IRQ_STATUS on the following edge.
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) deb_prev <= '0;
    else          deb_prev <= deb;
  end

  if (EDGE_MODE == 0) begin : g_rise
    assign edge_ev = deb & ~deb_prev;
  end else if (EDGE_MODE == 1) begin : g_fall
    assign edge_ev = ~deb & deb_prev;
  end else begin : g_both
    assign edge_ev = deb ^ deb_prev;
  end

  assign wr_gpo  = bus.we && (bus.addr == 2'd0);
  assign wr_mask = bus.we && (bus.addr == 2'd2);
  assign wr_stat = bus.we && (bus.addr == 2'd3);
  assign w1c     = wr_stat ? bus.wdata : '0;

  // OR-ing edge_ev after the clear makes a coincident set win over W1C.
  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      gpo      <= '0;
      irq_mask <= '0;
      irq_stat <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_gpo)  gpo      <= bus.wdata;
      if (wr_mask) irq_mask <= bus.wdata;
      irq_stat <= (irq_stat & ~w1c) | edge_ev;
      irq      <= |(irq_stat & irq_mask);
    end
  end

  // Mux reads current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      2'd0:    rd_mux = gpo;
      2'd1:    rd_mux = deb;
      2'd2:    rd_mux = irq_mask;
      default: rd_mux = irq_stat;
    endcase
  end

  always_ff @(posedge clk_fpga or negedge reset_n) begin
    if (!reset_n) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
    end else begin
      bus.rvalid <= bus.re;
      if (bus.re) bus.rdata <= rd_mux;
    end
  end
endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;
  localparam int W   = 8;
  localparam int DEB = 16;
  localparam int EM  = 0;
`ifdef GPIO_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif
  // cycles from a gpi change (driven at a negedge) to the debounced value
  localparam int LAT = DEB_EN ? 2 + DEB : 2;

  logic         clk_fpga = 1'b0;
  logic         reset_n  = 1'b0;
  logic [W-1:0] gpi      = '0;
  logic [W-1:0] gpo;
  logic         irq;

  gpio_bank_if #(.WIDTH(W)) bus ();

  gpio_bank #(.WIDTH(W), .DEB_CYCLES(DEB), .EDGE_MODE(EM)) dut (
    .clk_fpga (clk_fpga),
    .reset_n  (reset_n),
    .gpi      (gpi),
    .gpo      (gpo),
    .irq      (irq),
    .bus      (bus)
  );

  always #5 clk_fpga = ~clk_fpga;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [W-1:0] m_s1 = '0, m_s2 = '0, m_deb = '0, m_prev = '0;
  logic [W-1:0] m_gpo = '0, m_mask = '0, m_stat = '0, m_rdata = '0;
  logic         m_rvalid = 1'b0, m_irq = 1'b0;
  logic [W-1:0] m_hist[$];   // last DEB synchronized samples

  initial begin
    logic [W-1:0] d, ev, clr, nd;
    bit all_diff;
    forever begin
      @(posedge clk_fpga or negedge reset_n);
      if (!reset_n) begin
        m_s1 = '0; m_s2 = '0; m_deb = '0; m_prev = '0;
        m_gpo = '0; m_mask = '0; m_stat = '0; m_rdata = '0;
        m_rvalid = 1'b0; m_irq = 1'b0;
        m_hist.delete();
      end else begin
        d = DEB_EN ? m_deb : m_s2;
        if (bus.re) begin
          case (bus.addr)
            2'd0: m_rdata = m_gpo;
            2'd1: m_rdata = d;
            2'd2: m_rdata = m_mask;
            default: m_rdata = m_stat;
          endcase
        end
        m_rvalid = bus.re;
        ev  = (EM == 0) ? (d & ~m_prev) : (EM == 1) ? (~d & m_prev) : (d ^ m_prev);
        clr = (bus.we && bus.addr == 2'd3) ? bus.wdata : '0;
        m_irq  = |(m_stat & m_mask);
        m_stat = (m_stat & ~clr) | ev;
        if (bus.we && bus.addr == 2'd0) m_gpo  = bus.wdata;
        if (bus.we && bus.addr == 2'd2) m_mask = bus.wdata;
        // a bit flips once every one of the last DEB samples disagrees with it
        m_hist.push_back(m_s2);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        nd = m_deb;
        if (m_hist.size() == DEB) begin
          for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            foreach (m_hist[i]) if (m_hist[i][b] == m_deb[b]) all_diff = 1'b0;
            if (all_diff) nd[b] = ~m_deb[b];
          end
        end
        m_deb  = nd;
        m_prev = d;
        m_s2   = m_s1;
        m_s1   = gpi;
      end
    end
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk_fpga);
    chk ("cyc_gpo",    gpo,        m_gpo);
    chk ("cyc_rdata",  bus.rdata,  m_rdata);
    chk1("cyc_rvalid", bus.rvalid, m_rvalid);
    chk1("cyc_irq",    irq,        m_irq);
  end

  // ---------------- bus tasks ----------------
  task automatic wr(input logic [1:0] a, input logic [W-1:0] dat);
    @(negedge clk_fpga);
    bus.addr = a; bus.wdata = dat; bus.we = 1'b1;
    @(negedge clk_fpga);
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [W-1:0] dat);
    @(negedge clk_fpga);
    bus.addr = a; bus.re = 1'b1;
    @(negedge clk_fpga);
    bus.re = 1'b0;
    chk1("rd_rvalid", bus.rvalid, 1'b1);
    dat = bus.rdata;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [W-1:0] d;
    bus.addr = 2'd0; bus.we = 1'b0; bus.re = 1'b0; bus.wdata = '0;
    repeat (2) @(negedge clk_fpga);
    chk ("rst_gpo",    gpo,        8'h00);
    chk ("rst_rdata",  bus.rdata,  8'h00);
    chk1("rst_rvalid", bus.rvalid, 1'b0);
    chk1("rst_irq",    irq,        1'b0);
    reset_n = 1'b1;

    wr(2'd0, 8'hA5);
    chk("gpo_a5", gpo, 8'hA5);
    rd(2'd0, d);
    chk("rd_gpo", d, 8'hA5);
    @(negedge clk_fpga);
    chk1("rvalid_one_cycle", bus.rvalid, 1'b0);
    wr(2'd1, 8'h3C);                      // GPI is read-only
    rd(2'd1, d);
    chk("gpi_ro", d, 8'h00);

`ifdef GPIO_DEBOUNCE_EN
    @(negedge clk_fpga); gpi[1] = 1'b1;
    repeat (10) @(negedge clk_fpga);
    gpi[1] = 1'b0;
    repeat (DEB + 4) @(negedge clk_fpga);
    rd(2'd1, d); chk("glitch_gpi",  d, 8'h00);
    rd(2'd3, d); chk("glitch_stat", d, 8'h00);
`endif

    // masked rising edge on bit 0 -> irq, then W1C
    wr(2'd2, 8'h01);
    @(negedge clk_fpga); gpi[0] = 1'b1;
    repeat (LAT + 3) @(negedge clk_fpga);
    rd(2'd3, d); chk("stat_bit0", d, 8'h01);
    chk1("irq_bit0", irq, 1'b1);
    wr(2'd3, 8'h01);
    @(negedge clk_fpga);
    chk1("irq_after_w1c", irq, 1'b0);

    // unmasked edge sets status but not irq until mask opens
    wr(2'd2, 8'h00);
    @(negedge clk_fpga); gpi[3] = 1'b1;
    repeat (LAT + 3) @(negedge clk_fpga);
    rd(2'd3, d); chk("stat_bit3", d, 8'h08);
    chk1("irq_masked", irq, 1'b0);
    wr(2'd2, 8'h08);
    @(negedge clk_fpga);
    chk1("irq_unmasked", irq, 1'b1);
    wr(2'd3, 8'h08);
    wr(2'd2, 8'h00);

    // edge on bit 2 in the same cycle as W1C of bit 2: set wins
    @(negedge clk_fpga); gpi[2] = 1'b1;
    repeat (LAT - 1) @(negedge clk_fpga);
    wr(2'd3, 8'h04);
    rd(2'd3, d); chk("set_beats_clear", d, 8'h04);
    wr(2'd3, 8'hFF);

    // reset mid-debounce and mid-read
    @(negedge clk_fpga); gpi = 8'hFF;
    repeat (4) @(negedge clk_fpga);
    bus.addr = 2'd0; bus.re = 1'b1;
    #2 reset_n = 1'b0;
    @(negedge clk_fpga);
    bus.re = 1'b0;
    chk1("inflight_rvalid", bus.rvalid, 1'b0);
    chk ("rstmid_gpo",   gpo,       8'h00);
    chk ("rstmid_rdata", bus.rdata, 8'h00);
    chk1("rstmid_irq",   irq,       1'b0);
    @(negedge clk_fpga);
    reset_n = 1'b1;
    repeat (LAT + 2) @(negedge clk_fpga);
    rd(2'd1, d); chk("post_rst_gpi",  d, 8'hFF);
    rd(2'd3, d); chk("post_rst_stat", d, 8'hFF);

    // randomized traffic, checked every cycle by the model
    for (int n = 0; n < 3000; n++) begin
      int b;
      @(negedge clk_fpga);
      if ($urandom_range(0, 15) == 0) begin
        b = $urandom_range(0, W - 1);
        gpi[b] = ~gpi[b];
      end
      bus.we    = ($urandom_range(0, 3) == 0);
      bus.re    = ($urandom_range(0, 2) == 0);
      bus.addr  = 2'($urandom_range(0, 3));
      bus.wdata = W'($urandom);
    end
    @(negedge clk_fpga);
    bus.we = 1'b0; bus.re = 1'b0;
    repeat (4) @(negedge clk_fpga);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
